// File: rtl/adc_frame_sequencer.sv
// rtl/adc_frame_sequencer.sv - collects SPI ADC words into channel slots and publishes whole frames
module adc_frame_sequencer #(
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   spi_nss,
    input  logic                   word_received,
    input  logic [15:0]            word_in,
    input  logic                   error_clear,
    output logic [CHANNELS*16-1:0] ch_data,
    output logic                   frame_valid,
    output logic [CNT_W-1:0]       frame_count,
    output logic                   frame_error,
    output logic [1:0]             error_code,
    output logic [CNT_W-1:0]       error_count,
    output logic                   busy
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRAME = 3'd1,
        ST_DONE  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              nss_sync_q, nss_sync_d;
    logic [2:0]              wr_sync_q, wr_sync_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CHANNELS*16-1:0]  shadow_q, shadow_d;
    logic [CHANNELS*16-1:0]  ch_data_q, ch_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_error_q, frame_error_d;
    logic [1:0]              error_code_q, error_code_d;
    logic [CNT_W-1:0]        frame_count_q, frame_count_d;
    logic [CNT_W-1:0]        error_count_q, error_count_d;

    logic       nss_s, nss_fall, nss_rise, word_strobe;
    logic       err_set;
    logic [1:0] err_code;

    // Bit 1 is the synchronised level; bit 2 is its one-cycle-old copy for edge detection.
    assign nss_s       = nss_sync_q[1];
    assign nss_fall    = ~nss_sync_q[1] &  nss_sync_q[2];
    assign nss_rise    =  nss_sync_q[1] & ~nss_sync_q[2];
    assign word_strobe =  wr_sync_q[1]  & ~wr_sync_q[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            nss_sync_q    <= 3'b111;
            wr_sync_q     <= 3'b000;
            idx_q         <= '0;
            timer_q       <= '0;
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            error_code_q  <= 2'b00;
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            nss_sync_q    <= nss_sync_d;
            wr_sync_q     <= wr_sync_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            error_code_q  <= error_code_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
        end
    end

    always_comb begin
        nss_sync_d    = {nss_sync_q[1:0], spi_nss};
        wr_sync_d     = {wr_sync_q[1:0], word_received};
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        shadow_d      = shadow_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        error_code_d  = error_code_q;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        err_set       = 1'b0;
        err_code      = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (nss_fall) begin
                    state_d = ST_FRAME;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            ST_FRAME: begin
                // A word arriving with the chip-select release is stored before the release is judged.
                if (word_strobe) begin
                    shadow_d[16*int'(idx_q) +: 16] = word_in;
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (nss_rise) begin
                            err_set  = 1'b1;
                            err_code = 2'b01;
                        end
                    end
                end else if (nss_rise) begin
                    err_set  = 1'b1;
                    err_code = 2'b01;
                end else if (timer_q == TMR_MAX) begin
                    err_set  = 1'b1;
                    err_code = 2'b10;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                ch_data_d     = shadow_q;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + CNT_W'(1);
                state_d       = ST_TAIL;
            end
            ST_TAIL: begin
                // Level test so a release already seen alongside the final word still ends the frame.
                if (word_strobe) begin
                    err_set  = 1'b1;
                    err_code = 2'b11;
                end else if (nss_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (nss_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_set) begin
            state_d       = ST_ERROR;
            frame_error_d = 1'b1;
            error_code_d  = err_code;
            if (error_count_q != '1) error_count_d = error_count_q + CNT_W'(1);
        end
        if (error_clear) error_count_d = '0;
    end

    always_comb begin
        ch_data     = ch_data_q;
        frame_valid = frame_valid_q;
        frame_count = frame_count_q;
        frame_error = frame_error_q;
        error_code  = error_code_q;
        error_count = error_count_q;
        busy        = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb/tb_adc_frame_sequencer.sv - scoreboard bench for adc_frame_sequencer
module tb_adc_frame_sequencer;

    localparam int CH  = 4;
    localparam int TMO = 200;

    logic          clock = 1'b0;
    logic          reset;
    logic          spi_nss;
    logic          word_received;
    logic [15:0]   word_in;
    logic          error_clear;
    logic [CH*16-1:0] ch_data;
    logic          frame_valid;
    logic [7:0]    frame_count;
    logic          frame_error;
    logic [1:0]    error_code;
    logic [7:0]    error_count;
    logic          busy;

    adc_frame_sequencer #(.CHANNELS(CH), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .spi_nss       (spi_nss),
        .word_received (word_received),
        .word_in       (word_in),
        .error_clear   (error_clear),
        .ch_data       (ch_data),
        .frame_valid   (frame_valid),
        .frame_count   (frame_count),
        .frame_error   (frame_error),
        .error_code    (error_code),
        .error_count   (error_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        logic [1:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_fc  = 0;
    int   exp_ec  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_valid(input logic [63:0] d);
        exp_t e;
        exp_fc = (exp_fc + 1) % 256;
        e.is_err = 1'b0; e.data = d; e.code = 2'b00; e.cnt = 8'(exp_fc);
        exp_q.push_back(e);
    endtask

    task automatic push_error(input logic [1:0] c);
        exp_t e;
        if (exp_ec < 255) exp_ec++;
        e.is_err = 1'b1; e.data = '0; e.code = c; e.cnt = 8'(exp_ec);
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && (frame_valid || frame_error)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: valid=%0b error=%0b code=%0b, expected none", frame_valid, frame_error, error_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.is_err) begin
                    check("event_is_valid", 64'(frame_valid & ~frame_error), 64'd1);
                    check("ch_data", ch_data, e.data);
                    check("frame_count", 64'(frame_count), 64'(e.cnt));
                end else begin
                    check("event_is_error", 64'(frame_error & ~frame_valid), 64'd1);
                    check("error_code", 64'(error_code), 64'(e.code));
                    check("error_count", 64'(error_count), 64'(e.cnt));
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_word(input logic [15:0] w);
        word_in = w;
        word_received = 1'b1;
        clks(6);
        word_received = 1'b0;
        clks(14);
    endtask

    task automatic send_word_with_release(input logic [15:0] w);
        word_in = w;
        word_received = 1'b1;
        spi_nss = 1'b1;
        clks(6);
        word_received = 1'b0;
        clks(14);
    endtask

    task automatic nss_low();
        spi_nss = 1'b0;
        clks(10);
    endtask

    task automatic nss_high();
        spi_nss = 1'b1;
        clks(10);
    endtask

    task automatic check_reset_state();
        check("rst_ch_data", ch_data, 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_error_code", 64'(error_code), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({frame_valid, frame_error}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  seen;
        reset = 1'b1; spi_nss = 1'b1; word_received = 1'b0; word_in = 16'h0; error_clear = 1'b0;
        clks(5);
        reset = 1'b0;
        clks(3);
        check_reset_state();

        // good frame
        push_valid(64'h4444_3333_2222_1111);
        nss_low();
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333); send_word(16'h4444);
        nss_high();

        // short frame
        push_error(2'b01);
        nss_low();
        send_word(16'h9991); send_word(16'h9992);
        nss_high();
        check("short_keeps_ch_data", ch_data, 64'h4444_3333_2222_1111);

        // timeout: error TIMEOUT clocks after the sampling edge (3 edges after the raw rise)
        push_error(2'b10);
        nss_low();
        word_in = 16'h5A5A; word_received = 1'b1; cnt = 0; seen = 1'b0;
        while (!seen && cnt < TMO + 50) begin
            @(negedge clock);
            cnt++;
            if (cnt == 6) word_received = 1'b0;
            if (frame_error) seen = 1'b1;
        end
        check("timeout_latency", 64'(cnt), 64'(TMO + 3));
        nss_high();
        push_valid(64'hA004_A003_A002_A001);
        nss_low();
        send_word(16'hA001); send_word(16'hA002); send_word(16'hA003); send_word(16'hA004);
        nss_high();

        // overrun
        push_valid(64'hB004_B003_B002_B001);
        push_error(2'b11);
        nss_low();
        send_word(16'hB001); send_word(16'hB002); send_word(16'hB003); send_word(16'hB004);
        send_word(16'hB005);
        nss_high();
        check("overrun_keeps_ch_data", ch_data, 64'hB004_B003_B002_B001);

        // final word and release synchronised in the same cycle
        push_valid(64'hC004_C003_C002_C001);
        nss_low();
        send_word(16'hC001); send_word(16'hC002); send_word(16'hC003);
        send_word_with_release(16'hC004);
        clks(5);
        check("simul_last_idle", 64'(busy), 64'd0);

        push_error(2'b01);
        nss_low();
        send_word(16'hD001); send_word(16'hD002);
        send_word_with_release(16'hD003);
        clks(5);
        check("simul_third_ch_data", ch_data, 64'hC004_C003_C002_C001);

        // reset mid-frame
        nss_low();
        send_word(16'hEE01); send_word(16'hEE02);
        reset = 1'b1; spi_nss = 1'b1;
        clks(5);
        reset = 1'b0;
        exp_fc = 0; exp_ec = 0;
        clks(3);
        check_reset_state();
        push_valid(64'hE004_E003_E002_E001);
        nss_low();
        send_word(16'hE001); send_word(16'hE002); send_word(16'hE003); send_word(16'hE004);
        nss_high();
        check("mid_reset_error_count", 64'(error_count), 64'd0);

        // saturation
        for (int i = 0; i < 256; i++) begin
            push_error(2'b01);
            spi_nss = 1'b0; clks(6);
            spi_nss = 1'b1; clks(6);
        end
        check("sat_error_count", 64'(error_count), 64'd255);
        @(negedge clock); error_clear = 1'b1;
        @(negedge clock); error_clear = 1'b0;
        exp_ec = 0;
        check("clear_error_count", 64'(error_count), 64'd0);

        // clear coincident with an error increment: clear wins
        spi_nss = 1'b0; clks(6);
        begin
            exp_t e;
            e.is_err = 1'b1; e.data = '0; e.code = 2'b01; e.cnt = 8'd0;
            exp_q.push_back(e);
        end
        spi_nss = 1'b1;
        @(negedge clock);
        @(negedge clock);
        error_clear = 1'b1;
        @(negedge clock);
        error_clear = 1'b0;
        clks(10);
        check("clear_wins_count", 64'(error_count), 64'd0);
        check("error_code_held", 64'(error_code), 64'd1);
        check("final_frame_count", 64'(frame_count), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
